// File: rtl/clacc_pkg.sv
// Shared types and constants for the bit-serial accumulator controller.
package clacc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/fa_slice.sv
// 1-bit full adder from two half adders; the single adder slice reused every bit cycle.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic cout_c
);

    logic s0;
    logic c0;
    logic c1;

    ha u_ha0 (.a(a),  .b(b),   .sum_c(s0),    .carry_c(c0));
    ha u_ha1 (.a(s0), .b(cin), .sum_c(sum_c), .carry_c(c1));

    assign cout_c = c0 | c1;

endmodule

// File: rtl/ha.sv
// 1-bit half adder.
module ha (
    input  logic a,
    input  logic b,
    output logic sum_c,
    output logic carry_c
);

    assign sum_c   = a ^ b;
    assign carry_c = a & b;

endmodule

// File: rtl/serial_acc_ctrl.sv
// Bit-serial accumulator: adds each accepted operand into a persistent accumulator,
// one bit per clock LSB first, with valid/ready handshakes on both sides.
module serial_acc_ctrl
    import clacc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_acc_ctrl: WIDTH out of range");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;

    logic               bit_sum;
    logic               bit_carry;

    fa_slice u_fa (
        .a      (acc_q[0]),
        .b      (op_q[0]),
        .cin    (carry_q),
        .sum_c  (bit_sum),
        .cout_c (bit_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // Clear takes effect before the accept, so a same-cycle operand adds to zero.
                if (clr) begin
                    acc_d = '0;
                end
                if (in_valid && in_ready_q) begin
                    op_d    = in_data;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                acc_d   = {bit_sum, acc_q[WIDTH-1:1]};
                op_d    = op_q >> 1;
                carry_d = bit_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    ovf_d   = bit_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags follow the next state so they are registered yet cycle-accurate.
    always_comb begin
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_acc_ctrl.sv
// Self-checking bench for serial_acc_ctrl: transaction-level model plus directed vectors.
module tb_serial_acc_ctrl;

    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         clr       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         ovf;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_acc_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: result computed as a whole-word sum at accept time,
    // then revealed after W bit cycles until the consumer takes it.
    bit           m_rdy  = 1'b0;
    bit           m_done = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_acc  = '0;
    logic [W-1:0] m_res  = '0;
    bit           m_ovf  = 1'b0;
    logic [W:0]   m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy  = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_acc  = '0;
            m_res  = '0;
            m_ovf  = 1'b0;
        end else if (m_done) begin
            if (out_ready) begin
                m_done = 1'b0;
                m_rdy  = 1'b1;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else begin
            if (clr) m_acc = '0;
            if (m_rdy && in_valid) begin
                m_sum  = {1'b0, m_acc} + {1'b0, in_data};
                m_res  = m_sum[W-1:0];
                m_ovf  = m_sum[W];
                m_acc  = m_res;
                m_left = W;
                m_rdy  = 1'b0;
            end else begin
                m_rdy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready",  in_ready,  m_rdy);
        chk("m_out_valid", out_valid, m_done);
        chk("m_busy",      busy,      (m_left != 0) || m_done);
        if (m_done) begin
            chk("m_out_data", out_data, m_res);
            chk("m_ovf",      ovf,      m_ovf);
        end
        if (!rst_n) begin
            chk("m_rst_ovf",  ovf,      0);
            chk("m_rst_data", out_data, 0);
        end
    end

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input bit c, input bit noise, input int bp,
                        input logic [W-1:0] exp_d, input bit exp_o);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        clr      = c;
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (noise && n == 3) begin
                in_valid = 1'b1;
                clr      = 1'b1;
                in_data  = 8'hA5;
            end else begin
                in_valid = 1'b0;
                clr      = 1'b0;
            end
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        chk("latency", n,        W);
        chk("result",  out_data, exp_d);
        chk("ovf",     ovf,      exp_o);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data",  out_data,  exp_d);
            chk("bp_ovf",       ovf,       exp_o);
            chk("bp_in_ready",  in_ready,  0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_out_valid", out_valid, 0);
        chk("hs_in_ready",  in_ready,  1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready",  in_ready,  0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy",      busy,      0);
            chk("rst_ovf",       ovf,       0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        do_clr();
        send(8'd3,   1'b0, 1'b0, 0, 8'd3,  1'b0);
        send(8'd5,   1'b0, 1'b0, 0, 8'd8,  1'b0);

        do_clr();
        send(8'd200, 1'b0, 1'b0, 0, 8'd200, 1'b0);
        send(8'd100, 1'b0, 1'b0, 5, 8'd44,  1'b1);
        send(8'd1,   1'b0, 1'b0, 0, 8'd45,  1'b0);

        send(8'd5,   1'b0, 1'b0, 0, 8'd50,  1'b0);
        send(8'd7,   1'b1, 1'b0, 0, 8'd7,   1'b0);
        send(8'd10,  1'b0, 1'b1, 0, 8'd17,  1'b0);

        // Abort an add in flight with reset.
        in_valid = 1'b1;
        in_data  = 8'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  in_ready,  0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy",      busy,      0);
        chk("midrst_ovf",       ovf,       0);
        chk("midrst_out_data",  out_data,  0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("midrst_no_valid", out_valid, 0);
        end

        send(8'd9,   1'b0, 1'b0, 0, 8'd9,   1'b0);
        send(8'd247, 1'b0, 1'b0, 0, 8'd0,   1'b1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_acc_ctrl.md
Name: serial_acc_ctrl

Overview:
- Bit-serial accumulator controller. It time-shares one single-bit adder slice across a WIDTH-bit accumulation.
- Each accepted operand is added into a persistent accumulator, one bit per clock, LSB first.
- Used where area outweighs throughput: one adder slice replaces a WIDTH-bit carry chain.
- valid/ready handshakes on both input and output let it sit between a producer and a result consumer.

Parameters:
- WIDTH, 8, accumulator and operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous accumulator clear; honoured only in IDLE
- in_valid  input  1  operand valid
- in_ready  output  1  controller can accept an operand
- in_data  input  WIDTH  operand, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  accumulator value after the add
- ovf  output  1  carry-out of the most recent add; valid with out_valid
- busy  output  1  high in ADD or DONE

Behaviour:
- Reset (rst_n low, asynchronous): all registers and outputs go to 0 (state, accumulator, operand shift register, carry, counter, ovf, out_valid, busy). in_ready = 0 while rst_n is low, and 1 from the first clock cycle after release.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready = 1.
  - If clr is high at an edge, the accumulator loads 0.
  - If in_valid is high at an edge: latch in_data into the operand shift register, set carry = 0, set counter = 0, go to ADD.
  - clr and in_valid in the same cycle: the clear applies first, so the operand is added to 0.
- ADD (one bit per edge, WIDTH edges total):
  - s = acc[0] ^ op[0] ^ c.
  - c_next = majority(acc[0], op[0], c).
  - The accumulator shifts right with s entering the MSB; the operand shifts right.
  - The counter increments.
  - On the edge where counter == WIDTH-1: move to DONE and register ovf = c_next.
  - in_valid and clr are ignored; in_ready = 0.
- DONE:
  - out_valid = 1; out_data = accumulator (the full WIDTH-bit wrapped sum).
  - out_data and ovf hold stable while out_ready is low.
  - On an edge with out_ready high: out_valid drops and the state returns to IDLE.
- Latency:
  - The accepting edge is edge 0; out_valid rises after edge WIDTH.
  - Minimum issue interval is WIDTH+2 cycles (accept, WIDTH bit cycles, one handshake cycle).
  - The design has no bypass and no pipelining of back-to-back operands.
- Arithmetic: unsigned modulo 2^WIDTH. ovf is per-operation and not sticky.
- Reset asserted mid-operation aborts immediately. The partial accumulator is lost and no out_valid is produced.
- out_ready high outside DONE has no effect.
- The accumulator holds its value across IDLE indefinitely. Only clr or reset zeroes it.

Decomposition:
- Shared package clacc_pkg holds:
  - the state enum (IDLE, ADD, DONE) as a 2-bit typedef;
  - the WIDTH range-check constants.
- One sub-module, fa_slice: a 1-bit full adder built from two ha instances plus an OR for carry. The controller instantiates exactly one fa_slice. Sequencing, shift registers and handshakes stay in serial_acc_ctrl.

Test Plan:
- Reset/idle values: hold rst_n low for 3 cycles, then release.
  - During reset: in_ready=0, out_valid=0, busy=0, ovf=0.
  - From the first cycle after release: in_ready=1.
- Basic adds: after clr, send 8'd3, then 8'd5.
  - out_data=3, then out_data=8; ovf=0 both times.
  - out_valid rises exactly 8 edges after each accept.
- Overflow: clr, send 8'd200, then 8'd100.
  - Second result: out_data=8'd44, ovf=1.
  - Then send 8'd1: out_data=45, ovf=0.
- Backpressure: hold out_ready low for 5 cycles in DONE.
  - out_valid, out_data and ovf stay stable; in_ready stays 0.
  - Raise out_ready: out_valid is 0 next cycle and in_ready is 1.
- Simultaneous and ignored inputs:
  - With acc=50, assert clr and in_valid (8'd7) in the same IDLE cycle: result 7.
  - Pulse in_valid and clr during ADD: no effect, accumulator unchanged by them.
- Reset mid-ADD: assert rst_n low at bit 3 of an add.
  - All outputs go to 0 immediately and no out_valid appears.
  - After release, sending 8'd9 yields 9.
